// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: samples a multiplexed 7-segment bus (active-low segments,
// one-hot active-high digit select), filters it for stability, recovers each
// digit's hex nibble and presents complete frames on a valid/ready interface.
// Optional: define SEG7_DP_EN to also capture the decimal point per digit.

// Per-digit working slot: nibble, legal-glyph flag and seen-this-frame flag.
module seg7_digit_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,
  input  logic       legal,
  input  logic       clr_seen,
  input  logic [3:0] nib,
  output logic [3:0] slot_q,
  output logic       dv_q,
  output logic       seen_q
);
  logic [3:0] slot_d;
  logic       dv_d, seen_d;

  // Frame completion clears seen first; a capture in the same cycle still counts.
  always_comb begin
    slot_d = slot_q;
    dv_d   = dv_q;
    seen_d = clr_seen ? 1'b0 : seen_q;
    if (cap) begin
      if (legal) begin
        slot_d = nib;
        dv_d   = 1'b1;
        seen_d = 1'b1;
      end else begin
        dv_d   = 1'b0;
        seen_d = 1'b0;
      end
    end
  end

  // Slot state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      dv_q   <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      dv_q   <= dv_d;
      seen_q <= seen_d;
    end
  end
endmodule

module seg7_scan_encoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel,
  input  logic                      frame_ready,
`ifdef SEG7_DP_EN
  input  logic                      dp_in,
  output logic [NUM_DIGITS-1:0]     dp_out,
`endif
  output logic                      frame_valid,
  output logic [4*NUM_DIGITS-1:0]   bin_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      err,
  output logic [IW-1:0]             err_digit,
  output logic                      overrun
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  // Input sample and its previous-cycle copy for the stability compare
  logic [6:0]            s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0] s_sel_q, p_sel_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  one_hot, same, cap, legal;
  logic [3:0]            nib;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] lane_cap;

  logic [NUM_DIGITS-1:0][3:0] slot_q;
  logic [NUM_DIGITS-1:0]      dv_q, seen_q;
  logic                       complete;

  logic                    fv_q, fv_d, err_q, err_d, ovr_q, ovr_d;
  logic [4*NUM_DIGITS-1:0] bin_q, bin_d;
  logic [IW-1:0]           edig_q, edig_d;

`ifdef SEG7_DP_EN
  logic                  s_dp_q, p_dp_q;
  logic [NUM_DIGITS-1:0] dpw_q, dpw_d, dpo_q, dpo_d;
  assign same = ({s_sel_q, s_seg_q, s_dp_q} == {p_sel_q, p_seg_q, p_dp_q});
`else
  assign same = ({s_sel_q, s_seg_q} == {p_sel_q, p_seg_q});
`endif

  // Register the bus once, and keep last cycle's sample for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q <= '0;
      s_sel_q <= '0;
      p_seg_q <= '0;
      p_sel_q <= '0;
`ifdef SEG7_DP_EN
      s_dp_q  <= 1'b0;
      p_dp_q  <= 1'b0;
`endif
    end else begin
      s_seg_q <= seg_in;
      s_sel_q <= dig_sel;
      p_seg_q <= s_seg_q;
      p_sel_q <= s_sel_q;
`ifdef SEG7_DP_EN
      s_dp_q  <= dp_in;
      p_dp_q  <= s_dp_q;
`endif
    end
  end

  // Stability counter; capture fires only on the step that reaches the limit.
  always_comb begin
    one_hot = ($countones(s_sel_q) == 1);
    cnt_d   = cnt_q;
    if (!same || !one_hot) cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    cap = same && one_hot && (cnt_q == CNT_PRE);
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s_sel_q[i]) idx = IW'(i);
    lane_cap = cap ? s_sel_q : '0;
  end

  // Hex font lookup; anything else is an illegal glyph.
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (s_seg_q)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    seg7_digit_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (lane_cap[i]),
      .legal    (legal),
      .clr_seen (complete),
      .nib      (nib),
      .slot_q   (slot_q[i]),
      .dv_q     (dv_q[i]),
      .seen_q   (seen_q[i])
    );
  end

  assign complete = &seen_q;

  // Frame handoff: load on completion unless a held frame is still unaccepted.
  always_comb begin
    fv_d   = fv_q;
    bin_d  = bin_q;
    ovr_d  = 1'b0;
    if (complete) begin
      if (!fv_q || frame_ready) begin
        fv_d  = 1'b1;
        bin_d = slot_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
    err_d  = cap && !legal;
    edig_d = err_d ? idx : edig_q;
  end

  // Registered frame and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fv_q   <= 1'b0;
      bin_q  <= '0;
      ovr_q  <= 1'b0;
      err_q  <= 1'b0;
      edig_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
      bin_q  <= bin_d;
      ovr_q  <= ovr_d;
      err_q  <= err_d;
      edig_q <= edig_d;
    end
  end

`ifdef SEG7_DP_EN
  // Decimal point rides along with legal captures; stored as 1 = lit.
  always_comb begin
    dpw_d = dpw_q;
    dpo_d = dpo_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (lane_cap[i] && legal) dpw_d[i] = ~s_dp_q;
    if (complete && (!fv_q || frame_ready)) dpo_d = dpw_q;
  end

  // Decimal-point working slots and framed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpw_q <= '0;
      dpo_q <= '0;
    end else begin
      dpw_q <= dpw_d;
      dpo_q <= dpo_d;
    end
  end

  assign dp_out = dpo_q;
`endif

  assign frame_valid = fv_q;
  assign bin_out     = bin_q;
  assign digit_valid = dv_q;
  assign err         = err_q;
  assign err_digit   = edig_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Randomized + directed bench for seg7_scan_encoder against a sample-history model.
module tb_seg7_scan_encoder;
  localparam int ND = 2;
  localparam int S  = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [6:0]    seg_in = '0;
  logic [ND-1:0] dig_sel = '0;
  logic          frame_ready = 1'b0;
  logic          frame_valid, err, overrun;
  logic [4*ND-1:0] bin_out;
  logic [ND-1:0] digit_valid;
  logic          err_digit;
`ifdef SEG7_DP_EN
  logic          dp_in = 1'b1;
  logic [ND-1:0] dp_out;
`endif

  seg7_scan_encoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .frame_ready(frame_ready),
`ifdef SEG7_DP_EN
    .dp_in(dp_in), .dp_out(dp_out),
`endif
    .frame_valid(frame_valid), .bin_out(bin_out), .digit_valid(digit_valid),
    .err(err), .err_digit(err_digit), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_fv = 0, n_ovr = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: history of driven samples plus the frame/handshake rules.
  logic [3:0]      m_work [ND];
  logic [ND-1:0]   m_seen, e_dv, m_psel;
  logic [6:0]      m_pseg;
  logic [4*ND-1:0] e_bin;
  logic            e_fv, e_err, e_ovr;
  int              e_edig, m_run;
  bit              rdy_on_complete = 0;

  function automatic int glyph_idx(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ND; i++) m_work[i] = '0;
    m_seen = '0; e_dv = '0; m_psel = '0; m_pseg = '0;
    e_bin = '0; e_fv = 0; e_err = 0; e_ovr = 0; e_edig = 0; m_run = 0;
  endtask

  // One clock edge: a sample held for exactly S+1 consecutive edges is captured next edge.
  task automatic m_step();
    int d, g;
    e_err = 0; e_ovr = 0;
    if (m_seen == '1) begin
      if (!e_fv || frame_ready) begin
        e_fv = 1;
        for (int i = 0; i < ND; i++) e_bin[4*i +: 4] = m_work[i];
      end else e_ovr = 1;
      m_seen = '0;
    end else if (e_fv && frame_ready) e_fv = 0;
    if (m_run == S + 1 && $countones(m_psel) == 1) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (m_psel[i]) d = i;
      g = glyph_idx(m_pseg);
      if (g >= 0) begin
        m_work[d] = 4'(g); e_dv[d] = 1'b1; m_seen[d] = 1'b1;
      end else begin
        e_dv[d] = 1'b0; m_seen[d] = 1'b0; e_err = 1; e_edig = d;
      end
    end
    if (m_run > 0 && dig_sel == m_psel && seg_in == m_pseg) begin
      if (m_run < 100) m_run++;
    end else m_run = 1;
    m_psel = dig_sel; m_pseg = seg_in;
  endtask

  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      dig_sel = sel; seg_in = seg;
      if (rdy_on_complete) frame_ready = (m_seen == '1);
      @(posedge clk); #1;
      m_step();
      chk("bin_out", bin_out, e_bin);
      chk("frame_valid", frame_valid, e_fv);
      chk("digit_valid", digit_valid, e_dv);
      chk("err", err, e_err);
      chk("err_digit", err_digit, e_edig);
      chk("overrun", overrun, e_ovr);
      n_fv += frame_valid; n_ovr += overrun; n_err += err;
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear without a clock edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_bin", bin_out, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_dv", digit_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_edig", err_digit, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk); @(posedge clk);
    #4 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic frame(input logic [6:0] g0, input logic [6:0] g1, input int idle);
    drive(2'b01, g0, 6);
    drive(2'b10, g1, 6);
    drive(2'b00, 7'h7F, idle);
  endtask

  initial begin
    m_reset();
    async_reset();

    // 1: basic frame F2 with ready high
    frame_ready = 1; n_fv = 0; n_err = 0;
    frame(7'h24, 7'h0E, 3);
    chk("t1_bin", bin_out, 8'hF2);
    chk("t1_fv_cycles", n_fv, 1);
    chk("t1_dv", digit_valid, 2'b11);
    chk("t1_no_err", n_err, 0);

    // 2: toggling input must not capture; held value does
    async_reset();
    for (int k = 0; k < 10; k++) drive(2'b01, (k % 2) ? 7'h79 : 7'h40, 2);
    chk("t2_no_cap", digit_valid[0], 1'b0);
    drive(2'b01, 7'h79, 5);
    chk("t2_cap", digit_valid[0], 1'b1);

    // 3: illegal glyph on digit 1 blocks the frame until fixed
    n_err = 0; n_fv = 0;
    drive(2'b10, 7'h7F, 6);
    chk("t3_err_cnt", n_err, 1);
    chk("t3_edig", err_digit, 1);
    chk("t3_dv1", digit_valid[1], 1'b0);
    drive(2'b01, 7'h40, 6);
    drive(2'b00, 7'h7F, 3);
    chk("t3_no_frame", n_fv, 0);
    drive(2'b10, 7'h30, 6);
    drive(2'b00, 7'h7F, 2);
    chk("t3_bin", bin_out, 8'h30);

    // 4: backpressure, second frame dropped
    frame_ready = 0; drive(2'b00, 7'h7F, 2);
    n_ovr = 0;
    frame(7'h24, 7'h79, 2);
    frame(7'h19, 7'h30, 2);
    chk("t4_bin", bin_out, 8'h12);
    chk("t4_ovr", n_ovr, 1);
    frame_ready = 1; drive(2'b00, 7'h7F, 1);
    chk("t4_fv_clr", frame_valid, 1'b0);

    // 5: accept and complete on the same edge
    frame_ready = 0;
    frame(7'h24, 7'h79, 2);
    rdy_on_complete = 1;
    frame(7'h19, 7'h30, 1);
    rdy_on_complete = 0; frame_ready = 0;
    chk("t5_bin", bin_out, 8'h34);
    chk("t5_fv", frame_valid, 1'b1);

    // 6: reset mid-frame discards the stale digit; dig_sel=11 never captures
    async_reset();
    drive(2'b01, 7'h12, 6);
    async_reset();
    n_fv = 0; n_err = 0;
    drive(2'b10, 7'h02, 6);
    drive(2'b00, 7'h7F, 3);
    chk("t6_no_frame", n_fv, 0);
    drive(2'b11, 7'h40, 10);
    chk("t6_dv", digit_valid, 2'b10);
    chk("t6_no_err", n_err, 0);

    // Random bus traffic
    for (int it = 0; it < 400; it++) begin
      logic [ND-1:0] sel;
      logic [6:0]    seg;
      int r;
      r = $urandom_range(0, 9);
      sel = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      seg = ($urandom_range(0, 6) == 0) ? 7'($urandom) : GLYPH[$urandom_range(0, 15)];
      frame_ready = 1'($urandom);
      drive(sel, seg, $urandom_range(1, 7));
      if (it % 150 == 149) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
